// File: rtl/sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sprite_motion_ctrl
// Description : Per-frame position/velocity engine for one sprite. Decodes
//               WASD from packed USB keycodes, applies acceleration and
//               friction with a speed cap, and resolves playfield walls by
//               bounce or clamp.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_motion_ctrl #(
  parameter int X_MIN        = 100,
  parameter int X_MAX        = 539,
  parameter int Y_MIN        = 100,
  parameter int Y_MAX        = 379,
  parameter int X_CENTER     = 320,
  parameter int Y_CENTER     = 240,
  parameter int SIZE         = 4,
  parameter int MAX_SPEED    = 4,
  parameter int ACCEL_FRAMES = 4,
  parameter int KEY_SLOTS    = 4
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic [8*KEY_SLOTS-1:0] keycode,
  input  logic                   bounce_en,
  input  logic                   pause,
  input  logic                   respawn,
  output logic [9:0]             BallX,
  output logic [9:0]             BallY,
  output logic [9:0]             BallS,
  output logic [4:0]             VelX,
  output logic [4:0]             VelY,
  output logic [3:0]             wall_hit
);

  localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  localparam logic [CNT_W-1:0]   c_cnt_last = CNT_W'(ACCEL_FRAMES - 1);
  localparam logic signed [4:0]  c_vmax     = 5'(MAX_SPEED);
  localparam logic signed [11:0] c_size     = 12'(SIZE);
  localparam logic signed [11:0] c_x_min    = 12'(X_MIN);
  localparam logic signed [11:0] c_x_max    = 12'(X_MAX);
  localparam logic signed [11:0] c_y_min    = 12'(Y_MIN);
  localparam logic signed [11:0] c_y_max    = 12'(Y_MAX);

  // Result of resolving one axis against its pair of walls
  typedef struct packed {
    logic [9:0] pos;
    logic [4:0] vel;
    logic       hit_lo;
    logic       hit_hi;
  } axis_t;

  logic [9:0]           r_pos_x;
  logic [9:0]           r_pos_y;
  logic signed [4:0]    r_vel_x;
  logic signed [4:0]    r_vel_y;
  logic [CNT_W-1:0]     r_cnt;
  logic [3:0]           r_wall_hit;

  logic [KEY_SLOTS-1:0] w_slot_a;
  logic [KEY_SLOTS-1:0] w_slot_d;
  logic [KEY_SLOTS-1:0] w_slot_w;
  logic [KEY_SLOTS-1:0] w_slot_s;
  logic                 w_step_tick;
  logic signed [4:0]    w_vx_new;
  logic signed [4:0]    w_vy_new;
  axis_t                w_ax;
  axis_t                w_ay;

  // A key counts as pressed if any slot holds it, so slot order is irrelevant
  for (genvar i = 0; i < KEY_SLOTS; i++) begin : g_slot
    assign w_slot_a[i] = (keycode[8*i +: 8] == 8'h04);
    assign w_slot_d[i] = (keycode[8*i +: 8] == 8'h07);
    assign w_slot_w[i] = (keycode[8*i +: 8] == 8'h1A);
    assign w_slot_s[i] = (keycode[8*i +: 8] == 8'h16);
  end

  // One velocity step per axis on the tick: push toward the key direction with
  // saturation, or decay toward zero when no (or both opposing) keys are held.
  function automatic logic signed [4:0] f_vel_step(
    input logic signed [4:0] v,
    input logic              k_pos,
    input logic              k_neg,
    input logic              tick
  );
    logic signed [4:0] v_out;
    v_out = v;
    if (tick) begin
      if (k_pos && !k_neg)      v_out = (v >= c_vmax)  ? c_vmax  : v + 5'sd1;
      else if (k_neg && !k_pos) v_out = (v <= -c_vmax) ? -c_vmax : v - 5'sd1;
      else if (v > 5'sd0)       v_out = v - 5'sd1;
      else if (v < 5'sd0)       v_out = v + 5'sd1;
    end
    return v_out;
  endfunction

  // Move one axis by its new velocity in 12-bit signed space (so nothing wraps
  // through 0/1023), then clamp to the wall and bounce or stop on a hit.
  function automatic axis_t f_axis(
    input logic [9:0]         pos,
    input logic signed [4:0]  v_new,
    input logic signed [11:0] lo,
    input logic signed [11:0] hi,
    input logic               bounce
  );
    axis_t             a;
    logic signed [11:0] nxt;
    nxt      = $signed({2'b00, pos}) + $signed({{7{v_new[4]}}, v_new});
    a.pos    = nxt[9:0];
    a.vel    = v_new;
    a.hit_lo = 1'b0;
    a.hit_hi = 1'b0;
    if (nxt + c_size > hi) begin
      a.pos    = 10'(hi - c_size);
      a.vel    = bounce ? -v_new : 5'sd0;
      a.hit_hi = 1'b1;
    end else if (nxt - c_size < lo) begin
      a.pos    = 10'(lo + c_size);
      a.vel    = bounce ? -v_new : 5'sd0;
      a.hit_lo = 1'b1;
    end
    return a;
  endfunction

  assign w_step_tick = (r_cnt == c_cnt_last);
  assign w_vx_new    = f_vel_step(r_vel_x, |w_slot_d, |w_slot_a, w_step_tick);
  assign w_vy_new    = f_vel_step(r_vel_y, |w_slot_s, |w_slot_w, w_step_tick);
  assign w_ax        = f_axis(r_pos_x, w_vx_new, c_x_min, c_x_max, bounce_en);
  assign w_ay        = f_axis(r_pos_y, w_vy_new, c_y_min, c_y_max, bounce_en);

  // Frame update: reset > respawn (keeps accel phase) > pause (hold) > motion
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      r_pos_x    <= 10'(X_CENTER);
      r_pos_y    <= 10'(Y_CENTER);
      r_vel_x    <= 5'sd0;
      r_vel_y    <= 5'sd0;
      r_cnt      <= '0;
      r_wall_hit <= 4'b0000;
    end else if (respawn) begin
      r_pos_x    <= 10'(X_CENTER);
      r_pos_y    <= 10'(Y_CENTER);
      r_vel_x    <= 5'sd0;
      r_vel_y    <= 5'sd0;
      r_wall_hit <= 4'b0000;
    end else if (pause) begin
      r_wall_hit <= 4'b0000;
    end else begin
      r_cnt      <= w_step_tick ? '0 : r_cnt + 1'b1;
      r_pos_x    <= w_ax.pos;
      r_pos_y    <= w_ay.pos;
      r_vel_x    <= $signed(w_ax.vel);
      r_vel_y    <= $signed(w_ay.vel);
      r_wall_hit <= {w_ay.hit_lo, w_ay.hit_hi, w_ax.hit_lo, w_ax.hit_hi};
    end
  end

  assign BallX    = r_pos_x;
  assign BallY    = r_pos_y;
  assign BallS    = 10'(SIZE);
  assign VelX     = r_vel_x;
  assign VelY     = r_vel_y;
  assign wall_hit = r_wall_hit;

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_motion_ctrl
// Description : Directed self-checking bench for sprite_motion_ctrl with
//               hand-computed expected positions, velocities and wall flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_motion_ctrl;

  logic        frame_clk = 1'b0;
  logic        Reset_n;
  logic [31:0] keycode;
  logic        bounce_en;
  logic        pause;
  logic        respawn;
  logic [9:0]  BallX;
  logic [9:0]  BallY;
  logic [9:0]  BallS;
  logic [4:0]  VelX;
  logic [4:0]  VelY;
  logic [3:0]  wall_hit;

  int errors = 0;
  int checks = 0;

  sprite_motion_ctrl dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .keycode   (keycode),
    .bounce_en (bounce_en),
    .pause     (pause),
    .respawn   (respawn),
    .BallX     (BallX),
    .BallY     (BallY),
    .BallS     (BallS),
    .VelX      (VelX),
    .VelY      (VelY),
    .wall_hit  (wall_hit)
  );

  always #5 frame_clk = ~frame_clk;

  // Advance n frames and settle just after the last rising edge
  task automatic step(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n   = 1'b0;
    keycode   = 32'h0;
    bounce_en = 1'b1;
    pause     = 1'b0;
    respawn   = 1'b0;

    // Reset state
    step(2);
    chk("rst_x", BallX, 320);
    chk("rst_y", BallY, 240);
    chk("rst_vx", $signed(VelX), 0);
    chk("rst_vy", $signed(VelY), 0);
    chk("rst_wh", wall_hit, 0);
    chk("size", BallS, 4);

    // D held: velocity ramps every 4 frames, position follows on the same edge
    Reset_n = 1'b1;
    keycode = 32'h0000_0007;
    step(3);
    chk("d3_vx", $signed(VelX), 0);
    chk("d3_x", BallX, 320);
    step(1);
    chk("d4_vx", $signed(VelX), 1);
    chk("d4_x", BallX, 321);
    step(4);
    chk("d8_vx", $signed(VelX), 2);
    chk("d8_x", BallX, 326);
    step(8);
    chk("d16_vx", $signed(VelX), 4);
    chk("d16_x", BallX, 348);
    chk("d16_y", BallY, 240);
    step(46);
    chk("d62_x", BallX, 532);
    chk("d62_wh", wall_hit, 0);
    // Right wall bounce
    step(1);
    chk("rb_x", BallX, 535);
    chk("rb_vx", $signed(VelX), -4);
    chk("rb_wh", wall_hit, 4'b0001);
    step(1);
    chk("rb1_x", BallX, 532);
    chk("rb1_vx", $signed(VelX), -3);
    chk("rb1_wh", wall_hit, 0);

    // Respawn, then W (slot3) + A (slot0)
    keycode = 32'h0;
    respawn = 1'b1;
    step(1);
    chk("rsp_x", BallX, 320);
    chk("rsp_vx", $signed(VelX), 0);
    respawn = 1'b0;
    keycode = 32'h1A00_0004;
    step(4);
    chk("wa4_x", BallX, 319);
    chk("wa4_y", BallY, 239);
    chk("wa4_vx", $signed(VelX), -1);
    chk("wa4_vy", $signed(VelY), -1);
    step(4);
    chk("wa8_x", BallX, 314);
    chk("wa8_vy", $signed(VelY), -2);
    // A+D cancel: X decays, Y keeps accelerating
    keycode = 32'h1A00_0704;
    step(4);
    chk("ad12_x", BallX, 307);
    chk("ad12_y", BallY, 225);
    chk("ad12_vx", $signed(VelX), -1);
    chk("ad12_vy", $signed(VelY), -3);
    step(4);
    chk("ad16_x", BallX, 304);
    chk("ad16_y", BallY, 212);
    chk("ad16_vx", $signed(VelX), 0);
    chk("ad16_vy", $signed(VelY), -4);
    step(4);
    chk("ad20_y", BallY, 196);
    chk("ad20_vy", $signed(VelY), -4);
    // Exact touch of top wall is not a hit, then bounce
    step(23);
    chk("touch_y", BallY, 104);
    chk("touch_wh", wall_hit, 0);
    step(1);
    chk("tb_y", BallY, 104);
    chk("tb_vy", $signed(VelY), 4);
    chk("tb_wh", wall_hit, 4'b1000);
    chk("tb_x", BallX, 304);
    step(1);
    chk("tb1_y", BallY, 108);
    chk("tb1_wh", wall_hit, 0);

    // Respawn keeps accel phase; A in slot2 with clamp
    keycode = 32'h0;
    respawn = 1'b1;
    step(1);
    respawn   = 1'b0;
    keycode   = 32'h0004_0000;
    bounce_en = 1'b0;
    step(3);
    chk("cl3_vx", $signed(VelX), -1);
    chk("cl3_x", BallX, 319);
    step(8);
    chk("cl11_x", BallX, 305);
    step(51);
    chk("cl62_x", BallX, 104);
    chk("cl62_wh", wall_hit, 0);
    step(1);
    chk("cl63_x", BallX, 104);
    chk("cl63_vx", $signed(VelX), 0);
    chk("cl63_wh", wall_hit, 4'b0010);
    chk("cl63_y", BallY, 240);
    step(1);
    chk("cl64_wh", wall_hit, 0);

    // W (slot0) + A (slot2) into the top-left corner, clamped
    keycode = 32'h0004_001A;
    step(3);
    chk("c3_x", BallX, 104);
    chk("c3_wh", wall_hit, 4'b0010);
    chk("c3_y", BallY, 239);
    step(39);
    chk("c42_y", BallY, 104);
    chk("c42_wh", wall_hit, 0);
    step(1);
    chk("c43_y", BallY, 104);
    chk("c43_vy", $signed(VelY), 0);
    chk("c43_wh", wall_hit, 4'b1010);
    // Corner bounce
    bounce_en = 1'b1;
    step(4);
    chk("cb_x", BallX, 104);
    chk("cb_y", BallY, 104);
    chk("cb_vx", $signed(VelX), 1);
    chk("cb_vy", $signed(VelY), 1);
    chk("cb_wh", wall_hit, 4'b1010);
    step(1);
    chk("cb1_x", BallX, 105);
    chk("cb1_y", BallY, 105);
    chk("cb1_wh", wall_hit, 0);

    // Pause freezes position, velocity and the accel phase
    keycode = 32'h0;
    pause   = 1'b1;
    step(5);
    chk("p_x", BallX, 105);
    chk("p_vx", $signed(VelX), 1);
    chk("p_y", BallY, 105);
    chk("p_wh", wall_hit, 0);
    pause = 1'b0;
    step(2);
    chk("up2_x", BallX, 107);
    chk("up2_vx", $signed(VelX), 1);
    step(1);
    chk("up3_x", BallX, 107);
    chk("up3_vx", $signed(VelX), 0);

    // Reset mid-motion
    keycode = 32'h0000_0007;
    step(4);
    chk("m4_x", BallX, 108);
    chk("m4_vx", $signed(VelX), 1);
    step(2);
    Reset_n = 1'b0;
    step(1);
    chk("mr_x", BallX, 320);
    chk("mr_y", BallY, 240);
    chk("mr_vx", $signed(VelX), 0);
    Reset_n = 1'b1;
    step(4);
    chk("mr4_vx", $signed(VelX), 1);
    chk("mr4_x", BallX, 321);

    // Respawn wins over pause
    pause   = 1'b1;
    respawn = 1'b1;
    step(1);
    chk("rp_x", BallX, 320);
    chk("rp_vx", $signed(VelX), 0);
    pause   = 1'b0;
    respawn = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
